// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and phase-ordering helper for the traffic light monitor.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_R  = 2'b00,
    PH_RY = 2'b01,
    PH_G  = 2'b10,
    PH_Y  = 2'b11
  } phase_t;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Lamp patterns ordered {red, yellow, green}
  localparam logic [2:0] LAMP_R  = 3'b100;
  localparam logic [2:0] LAMP_RY = 3'b110;
  localparam logic [2:0] LAMP_G  = 3'b001;
  localparam logic [2:0] LAMP_Y  = 3'b010;

  function automatic phase_t next_phase(input phase_t ph);
    logic [1:0] nxt;
    nxt = ph + 2'd1;
    return phase_t'(nxt);
  endfunction

endpackage

// File: rtl/traffic_lamp_decoder.sv
// Combinational lamp-pattern decoder: {r,y,g} -> legal flag and phase code.
module traffic_lamp_decoder
  import traffic_pkg::*;
(
  input  logic [2:0] lamp_i,
  output logic       legal_o,
  output phase_t     phase_o
);

  always_comb begin
    legal_o = 1'b1;
    phase_o = PH_R;
    case (lamp_i)
      LAMP_R:  phase_o = PH_R;
      LAMP_RY: phase_o = PH_RY;
      LAMP_G:  phase_o = PH_G;
      LAMP_Y:  phase_o = PH_Y;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic signal checker: samples lamps, tracks R->RY->G->Y->R, measures dwell, flags faults.
// Two-cycle latency from lamp inputs to phase/error outputs.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] dwell,
  output logic             illegal_err,
  output logic             seq_err,
  output logic             dwell_err,
  output logic             cycle_done,
  output logic [15:0]      cycle_count
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [2:0]       lamp_q;
  logic             sample_vld_q;
  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             ill_q, ill_d, seq_q, seq_d, dwe_q, dwe_d;
  logic             cycle_done_q, cycle_done_d;
  logic [15:0]      cycle_count_q, cycle_count_d;
  logic             set_ill, set_seq, set_dwe;
  logic             dec_legal;
  phase_t           dec_phase;

  traffic_lamp_decoder u_dec (
    .lamp_i  (lamp_q),
    .legal_o (dec_legal),
    .phase_o (dec_phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  // lamp_q holds the reset value until the first real sample, so it is not judged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_q        <= 3'b000;
      sample_vld_q  <= 1'b0;
      phase_q       <= PH_R;
      dwell_q       <= '0;
      ill_q         <= 1'b0;
      seq_q         <= 1'b0;
      dwe_q         <= 1'b0;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      lamp_q        <= {red, yellow, green};
      sample_vld_q  <= 1'b1;
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      ill_q         <= ill_d;
      seq_q         <= seq_d;
      dwe_q         <= dwe_d;
      cycle_done_q  <= cycle_done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    dwell_d       = dwell_q;
    set_ill       = 1'b0;
    set_seq       = 1'b0;
    set_dwe       = 1'b0;
    cycle_done_d  = 1'b0;
    cycle_count_d = cycle_count_q;
    if (sample_vld_q) begin
      case (state_q)
        ST_SYNC: begin
          if (dec_legal) begin
            state_d = ST_TRACK;
            phase_d = dec_phase;
            dwell_d = ONE_C;
          end else begin
            set_ill = 1'b1;
          end
        end
        default: begin
          if (!dec_legal) begin
            set_ill = 1'b1;
            state_d = ST_SYNC;
            dwell_d = '0;
          end else if (dec_phase == phase_q) begin
            if (dwell_q != '1) dwell_d = dwell_q + ONE_C;
            if (dwell_q == MAX_C) set_dwe = 1'b1;
          end else if (dec_phase == next_phase(phase_q)) begin
            if (dwell_q < MIN_C) set_dwe = 1'b1;
            if (phase_q == PH_Y) begin
              cycle_done_d  = 1'b1;
              cycle_count_d = cycle_count_q + 16'd1;
            end
            phase_d = dec_phase;
            dwell_d = ONE_C;
          end else begin
            set_seq = 1'b1;
            phase_d = dec_phase;
            dwell_d = ONE_C;
          end
        end
      endcase
    end
    ill_d = set_ill | (ill_q & ~clr_err);
    seq_d = set_seq | (seq_q & ~clr_err);
    dwe_d = set_dwe | (dwe_q & ~clr_err);
  end

  always_comb begin
    phase       = phase_q;
    phase_valid = (state_q == ST_TRACK);
    dwell       = dwell_q;
    illegal_err = ill_q;
    seq_err     = seq_q;
    dwell_err   = dwe_q;
    cycle_done  = cycle_done_q;
    cycle_count = cycle_count_q;
  end

endmodule
